tree_traverser: RTL and testbench

Inference engine that walks one decision tree stored in a per-tree node ROM (`tree_rom_*`, 120-bit nodes, 1-cycle synchronous read). On `start` it fetches node 0. It then compares the selected IEEE-754 double feature against each node threshold and follows left or right child addresses until it reaches a leaf. It reports the leaf class with a `done` pulse. One instance sits between the feature buffer and the ensemble vote block, one per tree.

---
 rtl/tree_pkg.sv | 30 +++
 rtl/fp64_le.sv | 37 +++
 rtl/tree_traverser.sv | 167 ++++++++++++++++
 tb/tb_tree_traverser.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tree_pkg.sv
// Shared definitions for the decision-tree walker: node field layout,
// FSM state encoding and the leaf test.
package tree_pkg;

   localparam int NODE_ID_LSB  = 96;
   localparam int NODE_ID_W    = 12;
   localparam int FEAT_IDX_LSB = 92;
   localparam int FEAT_IDX_W   = 4;
   localparam int THRESH_LSB   = 28;
   localparam int THRESH_W     = 64;
   localparam int LEFT_LSB     = 16;
   localparam int RIGHT_LSB    = 4;
   localparam int CHILD_W      = 12;
   localparam int TAIL_LSB     = 0;
   localparam int TAIL_W       = 4;
   localparam int FP_W         = 64;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      EVAL
   } state_t;

   // Node 0 is never a child, so two zero child pointers mark a leaf.
   function automatic logic is_leaf(input logic [CHILD_W-1:0] left,
                                    input logic [CHILD_W-1:0] right);
      return (left == '0) && (right == '0);
   endfunction

endpackage

// File: rtl/fp64_le.sv
// Combinational IEEE-754 double ordered compare, o_le = (a <= b).
// NaN inputs give an arbitrary result.
module fp64_le
   import tree_pkg::*;
(
   input  logic [FP_W-1:0] i_a,
   input  logic [FP_W-1:0] i_b,
   output logic            o_le
);

   logic            w_sign_a;
   logic            w_sign_b;
   logic [FP_W-2:0] w_mag_a;
   logic [FP_W-2:0] w_mag_b;
   logic            w_both_zero;

   assign w_sign_a    = i_a[FP_W-1];
   assign w_sign_b    = i_b[FP_W-1];
   assign w_mag_a     = i_a[FP_W-2:0];
   assign w_mag_b     = i_b[FP_W-2:0];
   assign w_both_zero = (w_mag_a == '0) && (w_mag_b == '0);

   // Sign-magnitude ordering: negatives compare with reversed magnitude.
   always_comb begin
      o_le = 1'b0;
      if (w_both_zero) begin
         o_le = 1'b1;
      end else if (w_sign_a != w_sign_b) begin
         o_le = w_sign_a;
      end else if (!w_sign_a) begin
         o_le = (w_mag_a <= w_mag_b);
      end else begin
         o_le = (w_mag_a >= w_mag_b);
      end
   end

endmodule

// File: rtl/tree_traverser.sv
// Walks one decision tree held in an external synchronous node ROM and
// reports the leaf class, the number of internal nodes visited and an error flag.
//
//   state | meaning
//   IDLE  | waiting for start; outputs hold the last result
//   WAIT  | ROM read of rom_addr in flight
//   EVAL  | rom_data valid: finish on leaf/error, else fetch chosen child
module tree_traverser
   import tree_pkg::*;
#(
   parameter int NODE_WIDTH   = 120,
   parameter int ADDR_WIDTH   = 10,
   parameter int NUM_FEATURES = 16,
   parameter int FEAT_WIDTH   = 64,
   parameter int MAX_DEPTH    = 32
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             start,
   input  logic [NUM_FEATURES*FEAT_WIDTH-1:0] features,
   output logic [ADDR_WIDTH-1:0]            rom_addr,
   input  logic [NODE_WIDTH-1:0]            rom_data,
   output logic                             busy,
   output logic                             done,
   output logic [3:0]                       class_out,
   output logic [7:0]                       depth,
   output logic                             error
);

   localparam logic [7:0] MAX_DEPTH_C = 8'(MAX_DEPTH);

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [ADDR_WIDTH-1:0]   r_rom_addr;
   logic [ADDR_WIDTH-1:0]   w_addr_nxt;
   logic [7:0]              r_depth_cnt;
   logic [7:0]              w_cnt_nxt;
   logic                    r_busy;
   logic                    w_busy_nxt;
   logic                    r_done;
   logic                    w_done_nxt;
   logic [3:0]              r_class;
   logic [3:0]              w_class_nxt;
   logic [7:0]              r_depth;
   logic [7:0]              w_depth_nxt;
   logic                    r_error;
   logic                    w_error_nxt;

   logic [NODE_ID_W-1:0]    w_node_id;
   logic [FEAT_IDX_W-1:0]   w_feat_idx;
   logic [THRESH_W-1:0]     w_thresh;
   logic [CHILD_W-1:0]      w_left;
   logic [CHILD_W-1:0]      w_right;
   logic [TAIL_W-1:0]       w_tail;
   logic [FEAT_WIDTH-1:0]   w_feature;
   logic [FEAT_WIDTH-1:0]   w_feat_slot [NUM_FEATURES];
   logic                    w_go_left;
   logic                    w_id_ok;
   logic                    w_leaf;
   logic                    w_watchdog;
   logic [ADDR_WIDTH-1:0]   w_child;
   logic                    w_unused_bits;

   assign w_node_id     = rom_data[NODE_ID_LSB  +: NODE_ID_W];
   assign w_feat_idx    = rom_data[FEAT_IDX_LSB +: FEAT_IDX_W];
   assign w_thresh      = rom_data[THRESH_LSB   +: THRESH_W];
   assign w_left        = rom_data[LEFT_LSB     +: CHILD_W];
   assign w_right       = rom_data[RIGHT_LSB    +: CHILD_W];
   assign w_tail        = rom_data[TAIL_LSB     +: TAIL_W];
   assign w_unused_bits = ^rom_data[NODE_WIDTH-1:NODE_ID_LSB+NODE_ID_W];

   for (genvar g = 0; g < NUM_FEATURES; g++) begin : g_slot
      assign w_feat_slot[g] = features[g*FEAT_WIDTH +: FEAT_WIDTH];
   end

   assign w_feature = w_feat_slot[w_feat_idx];

   fp64_le u_cmp (
      .i_a  (w_feature),
      .i_b  (w_thresh),
      .o_le (w_go_left)
   );

   // The node must carry the id of the address it was fetched from.
   assign w_id_ok    = (w_node_id == {{(NODE_ID_W-ADDR_WIDTH){1'b0}}, r_rom_addr});
   assign w_leaf     = is_leaf(w_left, w_right);
   assign w_watchdog = (r_depth_cnt == MAX_DEPTH_C);
   assign w_child    = w_go_left ? w_left[ADDR_WIDTH-1:0] : w_right[ADDR_WIDTH-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_rom_addr  <= '0;
         r_depth_cnt <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_class     <= '0;
         r_depth     <= '0;
         r_error     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_rom_addr  <= w_addr_nxt;
         r_depth_cnt <= w_cnt_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_class     <= w_class_nxt;
         r_depth     <= w_depth_nxt;
         r_error     <= w_error_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_addr_nxt  = r_rom_addr;
      w_cnt_nxt   = r_depth_cnt;
      w_busy_nxt  = r_busy;
      w_done_nxt  = 1'b0;
      w_class_nxt = r_class;
      w_depth_nxt = r_depth;
      w_error_nxt = r_error;
      case (r_state)
         IDLE: begin
            if (start) begin
               w_addr_nxt  = '0;
               w_cnt_nxt   = '0;
               w_busy_nxt  = 1'b1;
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            w_state_nxt = EVAL;
         end
         EVAL: begin
            if (!w_id_ok || (!w_leaf && w_watchdog)) begin
               w_class_nxt = '0;
               w_depth_nxt = r_depth_cnt;
               w_error_nxt = 1'b1;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else if (w_leaf) begin
               w_class_nxt = w_tail;
               w_depth_nxt = r_depth_cnt;
               w_error_nxt = 1'b0;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else begin
               w_addr_nxt  = w_child;
               w_cnt_nxt   = r_depth_cnt + 8'd1;
               w_state_nxt = WAIT;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign rom_addr  = r_rom_addr;
   assign busy      = r_busy;
   assign done      = r_done;
   assign class_out = r_class;
   assign depth     = r_depth;
   assign error     = r_error;

endmodule

// File: tb/tb_tree_traverser.sv
// Self-checking bench for tree_traverser: random trees in a bench-owned ROM,
// checked against a tree walk that uses real-valued comparisons.
module tb_tree_traverser;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          start_a, start_b;
   logic [1023:0] features_a, features_b;
   logic [9:0]    rom_addr_a, rom_addr_b;
   logic [119:0]  rom_data_a, rom_data_b;
   logic          busy_a, done_a, error_a;
   logic          busy_b, done_b, error_b;
   logic [3:0]    class_a, class_b;
   logic [7:0]    depth_a, depth_b;

   logic [119:0]  mem_a [0:1023];
   logic [119:0]  mem_b [0:1023];
   logic [63:0]   feat [16];
   logic [63:0]   pool [8];

   int errors = 0;
   int checks = 0;

   always @(posedge clk) rom_data_a <= mem_a[rom_addr_a];
   always @(posedge clk) rom_data_b <= mem_b[rom_addr_b];

   tree_traverser u_dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .features(features_a),
      .rom_addr(rom_addr_a), .rom_data(rom_data_a), .busy(busy_a), .done(done_a),
      .class_out(class_a), .depth(depth_a), .error(error_a)
   );

   tree_traverser #(.MAX_DEPTH(4)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .features(features_b),
      .rom_addr(rom_addr_b), .rom_data(rom_data_b), .busy(busy_b), .done(done_b),
      .class_out(class_b), .depth(depth_b), .error(error_b)
   );

   function automatic logic [119:0] make_node(input logic [11:0] id, input logic [3:0] fidx,
                                              input logic [63:0] thr, input logic [11:0] l,
                                              input logic [11:0] r, input logic [3:0] tail);
      logic [11:0] junk;
      junk = 12'($urandom);
      return {junk, id, fidx, thr, l, r, tail};
   endfunction

   function automatic logic [63:0] pick_double();
      logic [63:0] v;
      logic [31:0] hi, lo;
      hi = $urandom;
      lo = $urandom;
      case ($urandom_range(0, 11))
         0: v = 64'h0000_0000_0000_0000;
         1: v = 64'h8000_0000_0000_0000;
         2: v = 64'h3FF0_0000_0000_0000;
         3: v = 64'hBFF0_0000_0000_0000;
         4: v = 64'h7FF0_0000_0000_0000;
         5: v = 64'hFFF0_0000_0000_0000;
         6: v = {32'h0, lo};
         7: v = {1'b1, 31'h0, lo};
         default: begin
            v = {hi, lo};
            if (v[62:52] == 11'h7FF) v[62] = 1'b0;
         end
      endcase
      return v;
   endfunction

   function automatic logic [11:0] child_field(input int x);
      return {2'($urandom_range(0, 3)), 10'(x)};
   endfunction

   task automatic clear_a();
      for (int i = 0; i < 1024; i++) mem_a[i] = '0;
   endtask

   task automatic clear_b();
      for (int i = 0; i < 1024; i++) mem_b[i] = '0;
   endtask

   task automatic apply_feat_a();
      for (int k = 0; k < 16; k++) features_a[k*64 +: 64] = feat[k];
   endtask

   task automatic random_feat();
      for (int k = 0; k < 8; k++) pool[k] = pick_double();
      for (int k = 0; k < 16; k++)
         feat[k] = ($urandom_range(0, 2) == 0) ? pick_double() : pool[$urandom_range(0, 7)];
      apply_feat_a();
   endtask

   // Breadth-first random tree, node addresses allocated in order from 1.
   task automatic gen_tree(input int maxd, input int leaf_pct, input bit corrupt);
      int qa[$];
      int qd[$];
      int nf, a, d, l, r;
      logic [63:0] thr;
      clear_a();
      qa.push_back(0);
      qd.push_back(0);
      nf = 1;
      while (qa.size() > 0) begin
         a = qa.pop_front();
         d = qd.pop_front();
         if (d >= maxd || (d > 0 && $urandom_range(0, 99) < leaf_pct)) begin
            mem_a[a] = make_node(12'(a), 4'($urandom_range(0, 15)), pick_double(),
                                 12'h0, 12'h0, 4'($urandom_range(0, 15)));
         end else begin
            l = nf;
            r = nf + 1;
            nf += 2;
            thr = ($urandom_range(0, 3) == 0) ? pick_double() : pool[$urandom_range(0, 7)];
            mem_a[a] = make_node(12'(a), 4'($urandom_range(0, 15)), thr,
                                 child_field(l), child_field(r), 4'($urandom_range(0, 15)));
            qa.push_back(l); qd.push_back(d + 1);
            qa.push_back(r); qd.push_back(d + 1);
         end
      end
      if (corrupt && nf > 1) begin
         a = $urandom_range(1, nf - 1);
         mem_a[a][107:96] = mem_a[a][107:96] + 12'd1;
      end
   endtask

   // Reference walk over the bench ROM using real-number ordering.
   task automatic model_a(input int maxd, output logic [3:0] cls, output int dep,
                          output bit err, output int n);
      logic [119:0] nd;
      logic [11:0]  l, r;
      logic [63:0]  f, t;
      int addr;
      addr = 0; dep = 0; n = 0; err = 0; cls = 0;
      while (n < 200) begin
         nd = mem_a[addr];
         n++;
         l = nd[27:16];
         r = nd[15:4];
         if (nd[107:96] != 12'(addr)) begin err = 1; cls = 0; break; end
         if (l == 12'h0 && r == 12'h0) begin cls = nd[3:0]; break; end
         if (dep == maxd) begin err = 1; cls = 0; break; end
         f = feat[nd[95:92]];
         t = nd[91:28];
         addr = ($bitstoreal(f) <= $bitstoreal(t)) ? int'(l[9:0]) : int'(r[9:0]);
         dep++;
      end
   endtask

   task automatic run_a(output int cyc);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      checks++;
      if (busy_a !== 1'b1) begin errors++; $display("FAIL busy_rise: busy=%0b expected 1", busy_a); end
      cyc = 0;
      while (cyc < 400) begin
         @(posedge clk); #1; cyc++;
         if (done_a === 1'b1) break;
      end
      checks++;
      if (done_a !== 1'b1) begin errors++; $display("FAIL done_a_timeout: done=%0b expected 1", done_a); end
   endtask

   task automatic run_b(input bit pulse, output int cyc);
      @(negedge clk); start_b = 1'b1;
      @(posedge clk); #1; start_b = 1'b0;
      cyc = 0;
      while (cyc < 400) begin
         @(posedge clk); #1; cyc++;
         start_b = pulse && (cyc == 2 || cyc == 5 || cyc == 7);
         if (done_b === 1'b1) break;
      end
      start_b = 1'b0;
      checks++;
      if (done_b !== 1'b1) begin errors++; $display("FAIL done_b_timeout: done=%0b expected 1", done_b); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0;
      features_a = '0; features_b = '0;
      clear_a(); clear_b();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({rom_addr_a, busy_a, done_a, class_a, depth_a, error_a} !== 25'h0) begin
         errors++;
         $display("FAIL reset_a: outputs=%h expected 0", {rom_addr_a, busy_a, done_a, class_a, depth_a, error_a});
      end
      checks++;
      if ({rom_addr_b, busy_b, done_b, class_b, depth_b, error_b} !== 25'h0) begin
         errors++;
         $display("FAIL reset_b: outputs=%h expected 0", {rom_addr_b, busy_b, done_b, class_b, depth_b, error_b});
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if ({busy_a, done_a, depth_a, error_a} !== 11'h0) begin
         errors++; $display("FAIL idle_after_reset: busy=%0b done=%0b expected 0", busy_a, done_a);
      end
   endtask

   task automatic test_compare();
      logic [63:0] cf [15] = '{64'h0, 64'h0, 64'h8000000000000000, 64'hBFF0000000000000,
                               64'hC000000000000000, 64'hBFF0000000000000, 64'h3FF0000000000000,
                               64'h7FF0000000000000, 64'hFFF0000000000000, 64'h0000000000000001,
                               64'h8000000000000001, 64'h3FF0000000000000, 64'hBFF0000000000000,
                               64'h4000000000000000, 64'h8000000000000000};
      logic [63:0] ct [15] = '{64'h0, 64'h8000000000000000, 64'h0, 64'hC000000000000000,
                               64'hBFF0000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
                               64'h7FEFFFFFFFFFFFFF, 64'hFFEFFFFFFFFFFFFF, 64'h0,
                               64'h8000000000000000, 64'h3FF0000000000000, 64'hBFF0000000000000,
                               64'h3FF0000000000000, 64'h8000000000000001};
      bit cl [15] = '{1, 1, 1, 0, 1, 1, 0, 0, 1, 0, 1, 1, 1, 0, 0};
      logic [3:0] ecls;
      int cyc;
      for (int i = 0; i < 15; i++) begin
         clear_a();
         mem_a[0] = make_node(12'd0, 4'd3, ct[i], 12'd1, 12'd2, 4'hF);
         mem_a[1] = make_node(12'd1, 4'd0, 64'h0, 12'd0, 12'd0, 4'd5);
         mem_a[2] = make_node(12'd2, 4'd0, 64'h0, 12'd0, 12'd0, 4'd10);
         for (int k = 0; k < 16; k++) feat[k] = 64'h0;
         feat[3] = cf[i];
         apply_feat_a();
         ecls = cl[i] ? 4'd5 : 4'd10;
         run_a(cyc);
         checks++;
         if (class_a !== ecls || depth_a !== 8'd1 || cyc != 4) begin
            errors++;
            $display("FAIL compare[%0d]: class=%0d depth=%0d cycles=%0d expected class=%0d depth=1 cycles=4",
                     i, class_a, depth_a, cyc, ecls);
         end
      end
   endtask

   task automatic test_integrity();
      int cyc;
      clear_a();
      mem_a[0] = make_node(12'd0, 4'd0, 64'h0, 12'd1, 12'h103, 4'h0);
      mem_a[1] = make_node(12'd1, 4'd0, 64'h0, 12'd0, 12'd0, 4'd6);
      for (int k = 0; k < 16; k++) feat[k] = 64'h0;
      feat[0] = 64'h3FF0000000000000;
      apply_feat_a();
      run_a(cyc);
      checks++;
      if (error_a !== 1'b1 || class_a !== 4'd0 || depth_a !== 8'd1 || cyc != 4) begin
         errors++;
         $display("FAIL integrity: error=%0b class=%0d depth=%0d cycles=%0d expected 1 0 1 4",
                  error_a, class_a, depth_a, cyc);
      end
   endtask

   task automatic test_random();
      logic [3:0] ecls;
      int edep, en, cyc;
      bit eerr;
      for (int it = 0; it < 40; it++) begin
         for (int k = 0; k < 8; k++) pool[k] = pick_double();
         gen_tree($urandom_range(1, 6), 30, ($urandom_range(0, 3) == 0));
         random_feat();
         model_a(32, ecls, edep, eerr, en);
         run_a(cyc);
         checks++;
         if (class_a !== ecls) begin errors++; $display("FAIL rand_class[%0d]: got %0d expected %0d", it, class_a, ecls); end
         checks++;
         if (depth_a !== 8'(edep)) begin errors++; $display("FAIL rand_depth[%0d]: got %0d expected %0d", it, depth_a, edep); end
         checks++;
         if (error_a !== eerr) begin errors++; $display("FAIL rand_error[%0d]: got %0b expected %0b", it, error_a, eerr); end
         checks++;
         if (cyc != 2 * en) begin errors++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", it, cyc, 2 * en); end
         checks++;
         if (busy_a !== 1'b0) begin errors++; $display("FAIL rand_busy_fall[%0d]: got %0b expected 0", it, busy_a); end
         @(posedge clk); #1;
         checks++;
         if (done_a !== 1'b0) begin errors++; $display("FAIL rand_done_pulse[%0d]: got %0b expected 0", it, done_a); end
         for (int k = 0; k < 16; k++) features_a[k*64 +: 64] = pick_double();
         repeat (2) @(posedge clk); #1;
         checks++;
         if (class_a !== ecls || error_a !== eerr) begin
            errors++; $display("FAIL rand_hold[%0d]: class=%0d expected %0d", it, class_a, ecls);
         end
      end
   endtask

   task automatic test_watchdog_main();
      int cyc;
      clear_a();
      for (int i = 0; i < 40; i++)
         mem_a[i] = make_node(12'(i), 4'd0, 64'h0, 12'(i + 1), 12'(i + 1), 4'd7);
      for (int k = 0; k < 16; k++) feat[k] = 64'h0;
      apply_feat_a();
      run_a(cyc);
      checks++;
      if (error_a !== 1'b1 || class_a !== 4'd0 || depth_a !== 8'd32 || cyc != 66) begin
         errors++;
         $display("FAIL watchdog_main: error=%0b class=%0d depth=%0d cycles=%0d expected 1 0 32 66",
                  error_a, class_a, depth_a, cyc);
      end
   endtask

   task automatic test_watchdog_small();
      int cyc, extra;
      clear_b();
      mem_b[0] = make_node(12'd0, 4'd0, 64'h0, 12'd1, 12'd1, 4'd3);
      mem_b[1] = make_node(12'd1, 4'd0, 64'h0, 12'd1, 12'd1, 4'd3);
      run_b(1'b1, cyc);
      checks++;
      if (error_b !== 1'b1 || depth_b !== 8'd4 || class_b !== 4'd0 || cyc != 10) begin
         errors++;
         $display("FAIL watchdog_small: error=%0b depth=%0d class=%0d cycles=%0d expected 1 4 0 10",
                  error_b, depth_b, class_b, cyc);
      end
      extra = 0;
      repeat (30) begin @(posedge clk); #1; if (done_b === 1'b1) extra++; end
      checks++;
      if (extra != 0) begin errors++; $display("FAIL start_while_busy: extra dones=%0d expected 0", extra); end
      clear_b();
      for (int i = 0; i < 4; i++)
         mem_b[i] = make_node(12'(i), 4'd0, 64'h0, 12'(i + 1), 12'(i + 1), 4'd3);
      mem_b[4] = make_node(12'd4, 4'd0, 64'h0, 12'd0, 12'd0, 4'd9);
      run_b(1'b0, cyc);
      checks++;
      if (error_b !== 1'b0 || depth_b !== 8'd4 || class_b !== 4'd9 || cyc != 10) begin
         errors++;
         $display("FAIL leaf_at_limit: error=%0b depth=%0d class=%0d cycles=%0d expected 0 4 9 10",
                  error_b, depth_b, class_b, cyc);
      end
   endtask

   task automatic test_back_to_back();
      logic [3:0] ecls;
      int edep, en, c, nd;
      int when [3];
      bit eerr;
      for (int k = 0; k < 8; k++) pool[k] = pick_double();
      gen_tree(3, 0, 1'b0);
      random_feat();
      model_a(32, ecls, edep, eerr, en);
      when = '{0, 0, 0};
      @(negedge clk); start_a = 1'b1;
      @(posedge clk);
      c = 0; nd = 0;
      while (nd < 3 && c < 300) begin
         @(posedge clk); #1; c++;
         if (done_a === 1'b1) begin
            when[nd] = c;
            nd++;
            if (nd == 3) start_a = 1'b0;
            checks++;
            if (class_a !== ecls) begin errors++; $display("FAIL b2b_class[%0d]: got %0d expected %0d", nd, class_a, ecls); end
         end
      end
      start_a = 1'b0;
      checks++;
      if (nd != 3) begin errors++; $display("FAIL b2b_count: got %0d expected 3", nd); end
      checks++;
      if (when[0] != 2 * en) begin errors++; $display("FAIL b2b_first: got %0d expected %0d", when[0], 2 * en); end
      checks++;
      if (when[1] - when[0] != 2 * en + 1) begin
         errors++; $display("FAIL b2b_period1: got %0d expected %0d", when[1] - when[0], 2 * en + 1);
      end
      checks++;
      if (when[2] - when[1] != 2 * en + 1) begin
         errors++; $display("FAIL b2b_period2: got %0d expected %0d", when[2] - when[1], 2 * en + 1);
      end
      @(posedge clk); #1;
      checks++;
      if (busy_a !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%0b expected 0", busy_a); end
   endtask

   task automatic test_reset_midflight();
      logic [3:0] ecls;
      int edep, en, cyc, nd;
      bit eerr;
      for (int k = 0; k < 8; k++) pool[k] = pick_double();
      gen_tree(3, 0, 1'b0);
      random_feat();
      model_a(32, ecls, edep, eerr, en);
      run_a(cyc);
      @(negedge clk); start_a = 1'b1;
      @(posedge clk); #1; start_a = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({rom_addr_a, busy_a, done_a, class_a, depth_a, error_a} !== 25'h0) begin
         errors++;
         $display("FAIL reset_midflight: outputs=%h expected 0", {rom_addr_a, busy_a, done_a, class_a, depth_a, error_a});
      end
      @(negedge clk); rst_n = 1'b1;
      nd = 0;
      repeat (30) begin @(posedge clk); #1; if (done_a === 1'b1) nd++; end
      checks++;
      if (nd != 0 || busy_a !== 1'b0) begin
         errors++; $display("FAIL aborted_done: dones=%0d busy=%0b expected 0 0", nd, busy_a);
      end
      run_a(cyc);
      checks++;
      if (class_a !== ecls || depth_a !== 8'(edep) || error_a !== eerr || cyc != 2 * en) begin
         errors++;
         $display("FAIL restart: class=%0d depth=%0d error=%0b cycles=%0d expected %0d %0d %0b %0d",
                  class_a, depth_a, error_a, cyc, ecls, edep, eerr, 2 * en);
      end
   endtask

   initial begin
      test_reset();
      test_compare();
      test_integrity();
      test_random();
      test_watchdog_main();
      test_watchdog_small();
      test_back_to_back();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running at time limit");
      $fatal(1, "time limit");
   end

endmodule
